// File: rtl/reg_coef_pkg.sv
// Shared constants, FSM state encoding and the output round/saturate helper
// for the least-squares coefficient stage.
package reg_coef_pkg;
    localparam int ACC_W  = 74;
    localparam int PROD_W = 66;

    localparam int DEF_INV0_FRAC = 10;
    localparam int DEF_INV1_FRAC = 8;
    localparam int DEF_INV2_FRAC = 6;
    localparam int DEF_SY_FRAC   = 4;
    localparam int DEF_SXY_FRAC  = 8;
    localparam int DEF_ACC_FRAC  = 18;
    localparam int DEF_OUT_W     = 32;
    localparam int DEF_OUT_FRAC  = 8;

    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_M0   = 3'd1;
    localparam logic [2:0] ST_M1   = 3'd2;
    localparam logic [2:0] ST_M2   = 3'd3;
    localparam logic [2:0] ST_M3   = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    typedef struct packed {
        logic                    sat;
        logic signed [ACC_W-1:0] value;
    } round_sat_t;

    // Round half up by dropping 'shift' fraction bits, then clip to a signed out_w range.
    function automatic round_sat_t round_sat(input logic signed [ACC_W-1:0] acc,
                                             input int shift, input int out_w);
        logic signed [ACC_W-1:0] one;
        logic signed [ACC_W-1:0] rnd;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        round_sat_t res;
        one = ACC_W'(1);
        rnd = acc;
        if (shift > 0) begin
            rnd = (acc + (one <<< (shift - 1))) >>> shift;
        end
        hi = (one <<< (out_w - 1)) - one;
        lo = -hi - one;
        res.sat   = 1'b0;
        res.value = rnd;
        if (rnd > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (rnd < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction
endpackage

// File: rtl/reg_coef_solve_if.sv
// Operand/result bundle of the coefficient stage: inverse and moment inputs
// from upstream, betas and status towards the continuation-value estimator.
interface reg_coef_solve_if #(
    parameter int OUT_W = 32
);
    logic                    inv_valid;
    logic signed [31:0]      inv0;
    logic signed [19:0]      inv1;
    logic signed [20:0]      inv2;
    logic                    xty_valid;
    logic [32:0]             sy;
    logic [32:0]             sxy;
    logic                    busy;
    logic                    beta_valid;
    logic signed [OUT_W-1:0] beta0;
    logic signed [OUT_W-1:0] beta1;
    logic                    sat;

    modport master (
        output inv_valid, inv0, inv1, inv2, xty_valid, sy, sxy,
        input  busy, beta_valid, beta0, beta1, sat
    );

    modport slave (
        input  inv_valid, inv0, inv1, inv2, xty_valid, sy, sxy,
        output busy, beta_valid, beta0, beta1, sat
    );
endinterface

// File: rtl/coef_mac.sv
// Time-shared signed multiplier with per-term alignment into two accumulators.
// sel[1] picks acc0/acc1, sel[0]=0 loads the aligned product, sel[0]=1 adds it.
module coef_mac
    import reg_coef_pkg::*;
#(
    parameter int INV0_FRAC = DEF_INV0_FRAC,
    parameter int INV1_FRAC = DEF_INV1_FRAC,
    parameter int INV2_FRAC = DEF_INV2_FRAC,
    parameter int SY_FRAC   = DEF_SY_FRAC,
    parameter int SXY_FRAC  = DEF_SXY_FRAC,
    parameter int ACC_FRAC  = DEF_ACC_FRAC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              sel,
    input  logic signed [31:0]      inv0,
    input  logic signed [19:0]      inv1,
    input  logic signed [20:0]      inv2,
    input  logic [32:0]             sy,
    input  logic [32:0]             sxy,
    output logic signed [ACC_W-1:0] acc0,
    output logic signed [ACC_W-1:0] acc1
);
    localparam int SH0 = ACC_FRAC - (INV0_FRAC + SY_FRAC);
    localparam int SH1 = ACC_FRAC - (INV1_FRAC + SXY_FRAC);
    localparam int SH2 = ACC_FRAC - (INV1_FRAC + SY_FRAC);
    localparam int SH3 = ACC_FRAC - (INV2_FRAC + SXY_FRAC);

    logic signed [PROD_W-1:0] op_a;
    logic signed [PROD_W-1:0] op_b;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  aligned;
    int                       shamt;

    // Both operands are widened to the product width so the multiply is exact in 66 bits.
    always_comb begin
        op_a  = {{34{inv0[31]}}, inv0};
        op_b  = {33'd0, sy};
        shamt = SH0;
        case (sel)
            2'd1: begin
                op_a  = {{46{inv1[19]}}, inv1};
                op_b  = {33'd0, sxy};
                shamt = SH1;
            end
            2'd2: begin
                op_a  = {{46{inv1[19]}}, inv1};
                op_b  = {33'd0, sy};
                shamt = SH2;
            end
            2'd3: begin
                op_a  = {{45{inv2[20]}}, inv2};
                op_b  = {33'd0, sxy};
                shamt = SH3;
            end
            default: ;
        endcase
    end

    assign product = op_a * op_b;
    assign aligned = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product} <<< shamt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_acc
            logic signed [ACC_W-1:0] acc_reg;
            logic                    hit;
            assign hit = en && (sel[1] == 1'(gi));
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (hit) begin
                    acc_reg <= sel[0] ? acc_reg + aligned : aligned;
                end
            end
        end
    endgenerate

    assign acc0 = g_acc[0].acc_reg;
    assign acc1 = g_acc[1].acc_reg;
endmodule

// File: rtl/reg_coef_solve.sv
// Solves beta = inv(XtX) * XtY for the 2x2 case: captures operands on rising
// valid edges, runs four MAC cycles, then rounds/saturates into the outputs.
module reg_coef_solve
    import reg_coef_pkg::*;
#(
    parameter int INV0_FRAC = DEF_INV0_FRAC,
    parameter int INV1_FRAC = DEF_INV1_FRAC,
    parameter int INV2_FRAC = DEF_INV2_FRAC,
    parameter int SY_FRAC   = DEF_SY_FRAC,
    parameter int SXY_FRAC  = DEF_SXY_FRAC,
    parameter int ACC_FRAC  = DEF_ACC_FRAC,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int OUT_FRAC  = DEF_OUT_FRAC
) (
    input  logic          clk,
    input  logic          rst,
    reg_coef_solve_if.slave bus
);
    logic [2:0]              state_reg;
    logic                    prev_inv_reg, prev_xty_reg;
    logic                    have_inv_reg, have_xty_reg;
    logic signed [31:0]      inv0_reg;
    logic signed [19:0]      inv1_reg;
    logic signed [20:0]      inv2_reg;
    logic [32:0]             sy_reg, sxy_reg;
    logic                    beta_valid_reg, sat_reg;
    logic signed [OUT_W-1:0] beta0_reg, beta1_reg;

    logic                    inv_edge, xty_edge;
    logic                    mac_en;
    logic [1:0]              mac_sel;
    logic signed [ACC_W-1:0] acc0, acc1;
    round_sat_t              rs0, rs1;
    logic                    unused_hi_bits;

    assign inv_edge = bus.inv_valid & ~prev_inv_reg;
    assign xty_edge = bus.xty_valid & ~prev_xty_reg;

    always_comb begin
        mac_en  = 1'b1;
        mac_sel = 2'd0;
        case (state_reg)
            ST_M0:   mac_sel = 2'd0;
            ST_M1:   mac_sel = 2'd1;
            ST_M2:   mac_sel = 2'd2;
            ST_M3:   mac_sel = 2'd3;
            default: mac_en  = 1'b0;
        endcase
    end

    coef_mac #(
        .INV0_FRAC (INV0_FRAC),
        .INV1_FRAC (INV1_FRAC),
        .INV2_FRAC (INV2_FRAC),
        .SY_FRAC   (SY_FRAC),
        .SXY_FRAC  (SXY_FRAC),
        .ACC_FRAC  (ACC_FRAC)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (mac_en),
        .sel  (mac_sel),
        .inv0 (inv0_reg),
        .inv1 (inv1_reg),
        .inv2 (inv2_reg),
        .sy   (sy_reg),
        .sxy  (sxy_reg),
        .acc0 (acc0),
        .acc1 (acc1)
    );

    assign rs0 = round_sat(acc0, ACC_FRAC - OUT_FRAC, OUT_W);
    assign rs1 = round_sat(acc1, ACC_FRAC - OUT_FRAC, OUT_W);
    // After clipping the bits above OUT_W are only sign copies.
    assign unused_hi_bits = ^{rs0.value[ACC_W-1:OUT_W], rs1.value[ACC_W-1:OUT_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_WAIT;
            prev_inv_reg   <= 1'b0;
            prev_xty_reg   <= 1'b0;
            have_inv_reg   <= 1'b0;
            have_xty_reg   <= 1'b0;
            inv0_reg       <= '0;
            inv1_reg       <= '0;
            inv2_reg       <= '0;
            sy_reg         <= '0;
            sxy_reg        <= '0;
            beta_valid_reg <= 1'b0;
            sat_reg        <= 1'b0;
            beta0_reg      <= '0;
            beta1_reg      <= '0;
        end else begin
            prev_inv_reg   <= bus.inv_valid;
            prev_xty_reg   <= bus.xty_valid;
            beta_valid_reg <= 1'b0;
            case (state_reg)
                ST_WAIT: begin
                    if (inv_edge) begin
                        inv0_reg     <= bus.inv0;
                        inv1_reg     <= bus.inv1;
                        inv2_reg     <= bus.inv2;
                        have_inv_reg <= 1'b1;
                    end
                    if (xty_edge) begin
                        sy_reg       <= bus.sy;
                        sxy_reg      <= bus.sxy;
                        have_xty_reg <= 1'b1;
                    end
                    if (have_inv_reg && have_xty_reg) begin
                        state_reg <= ST_M0;
                    end
                end
                ST_M0: state_reg <= ST_M1;
                ST_M1: state_reg <= ST_M2;
                ST_M2: state_reg <= ST_M3;
                ST_M3: state_reg <= ST_FIN;
                ST_FIN: begin
                    beta0_reg      <= rs0.value[OUT_W-1:0];
                    beta1_reg      <= rs1.value[OUT_W-1:0];
                    sat_reg        <= rs0.sat | rs1.sat;
                    beta_valid_reg <= 1'b1;
                    have_inv_reg   <= 1'b0;
                    have_xty_reg   <= 1'b0;
                    state_reg      <= ST_WAIT;
                end
                default: state_reg <= ST_WAIT;
            endcase
        end
    end

    assign bus.busy       = (state_reg != ST_WAIT);
    assign bus.beta_valid = beta_valid_reg;
    assign bus.beta0      = beta0_reg;
    assign bus.beta1      = beta1_reg;
    assign bus.sat        = sat_reg;
endmodule

// File: tb/tb_reg_coef_solve.sv
// Self-checking bench for reg_coef_solve: directed scenarios plus randomized
// transactions checked against an exact wide-integer model of the betas.
module tb_reg_coef_solve;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    reg_coef_solve_if #(.OUT_W(32)) bus ();

    reg_coef_solve dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [31:0] v_inv0;
    logic signed [19:0] v_inv1;
    logic signed [20:0] v_inv2;
    logic [32:0]        v_sy, v_sxy;

    // beta = a*xa + b*xb as real numbers, reported with 8 fraction bits, rounded half up, clipped to int32.
    function automatic logic signed [31:0] model_beta(
        input logic signed [31:0] ia, input int fa, input logic signed [31:0] ib, input int fb,
        input logic [32:0] xa, input int fxa, input logic [32:0] xb, input int fxb, output bit s);
        logic signed [127:0] ea, eb, exa, exb, sum, q, hi, lo;
        ea  = ia;
        eb  = ib;
        exa = {95'd0, xa};
        exb = {95'd0, xb};
        sum = ea * exa * (128'sd1 <<< (18 - fa - fxa)) + eb * exb * (128'sd1 <<< (18 - fb - fxb));
        q   = (sum + 128'sd512) >>> 10;
        hi  = 128'sd2147483647;
        lo  = -128'sd2147483648;
        s   = 1'b0;
        if (q > hi) begin
            q = hi;
            s = 1'b1;
        end else if (q < lo) begin
            q = lo;
            s = 1'b1;
        end
        return q[31:0];
    endfunction

    task automatic compute_expect(output logic signed [31:0] e0, output logic signed [31:0] e1,
                                  output bit es);
        bit s0, s1;
        e0 = model_beta(v_inv0, 10, v_inv1, 8, v_sy, 4, v_sxy, 8, s0);
        e1 = model_beta(v_inv1, 8, v_inv2, 6, v_sy, 4, v_sxy, 8, s1);
        es = s0 | s1;
    endtask

    task automatic apply_inv(input logic signed [31:0] a, input logic signed [19:0] b,
                             input logic signed [20:0] c);
        v_inv0 = a; v_inv1 = b; v_inv2 = c;
        bus.inv0 = a; bus.inv1 = b; bus.inv2 = c;
    endtask

    task automatic apply_xty(input logic [32:0] a, input logic [32:0] b);
        v_sy = a; v_sxy = b;
        bus.sy = a; bus.sxy = b;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the capturing edge; inv_valid is left high, xty_valid is a one-cycle pulse.
    task automatic fire(input bit do_inv, input bit do_xty);
        if (do_inv) begin
            bus.inv_valid = 1'b0;
            idle();
            bus.inv_valid = 1'b1;
        end
        if (do_xty) bus.xty_valid = 1'b1;
        idle();
        bus.xty_valid = 1'b0;
    endtask

    task automatic wait_beta(input int max_cyc, output int lat, output bit seen);
        seen = 1'b0;
        lat  = -1;
        for (int i = 1; i <= max_cyc && !seen; i++) begin
            idle();
            if (bus.beta_valid === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.beta_valid !== 1'b0) $display("FAIL reset_beta_valid: got %b expected 0", bus.beta_valid); else pass_cnt++;
        total_cnt++; if (bus.beta0 !== 32'sd0) $display("FAIL reset_beta0: got %0d expected 0", bus.beta0); else pass_cnt++;
        total_cnt++; if (bus.beta1 !== 32'sd0) $display("FAIL reset_beta1: got %0d expected 0", bus.beta1); else pass_cnt++;
        total_cnt++; if (bus.sat !== 1'b0) $display("FAIL reset_sat: got %b expected 0", bus.sat); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
    endtask

    task automatic test_basic();
        int lat;
        bit seen;
        logic signed [31:0] e0, e1;
        for (int k = 0; k < 2; k++) begin
            apply_inv(32'sd1024, (k == 0) ? 20'sd0 : -20'sd128, 21'sd64);
            apply_xty(33'd16, 33'd512);
            e0 = (k == 0) ? 32'sd256 : 32'sd0;
            e1 = (k == 0) ? 32'sd512 : 32'sd384;
            fire(1'b1, 1'b1);
            wait_beta(20, lat, seen);
            total_cnt++; if (!seen || lat != 6) $display("FAIL basic_latency[%0d]: got %0d expected 6", k, lat); else pass_cnt++;
            total_cnt++; if (bus.beta0 !== e0) $display("FAIL basic_beta0[%0d]: got %0d expected %0d", k, bus.beta0, e0); else pass_cnt++;
            total_cnt++; if (bus.beta1 !== e1) $display("FAIL basic_beta1[%0d]: got %0d expected %0d", k, bus.beta1, e1); else pass_cnt++;
            total_cnt++; if (bus.sat !== 1'b0) $display("FAIL basic_sat[%0d]: got %b expected 0", k, bus.sat); else pass_cnt++;
            idle();
            total_cnt++; if (bus.beta_valid !== 1'b0) $display("FAIL basic_pulse_width[%0d]: got %b expected 0", k, bus.beta_valid); else pass_cnt++;
            total_cnt++; if (bus.beta0 !== e0) $display("FAIL basic_hold[%0d]: got %0d expected %0d", k, bus.beta0, e0); else pass_cnt++;
        end
    endtask

    task automatic test_overwrite();
        int lat, busy_hits, bv_hits;
        bit seen;
        busy_hits = 0;
        bv_hits   = 0;
        apply_inv(32'sd1024, -20'sd128, 21'sd64);
        bus.inv_valid = 1'b0;
        apply_xty(33'd16, 33'd1024);
        fire(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle();
            busy_hits += int'(bus.busy);
            bv_hits   += int'(bus.beta_valid);
        end
        apply_xty(33'd16, 33'd512);
        fire(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle();
            busy_hits += int'(bus.busy);
            bv_hits   += int'(bus.beta_valid);
        end
        total_cnt++; if (busy_hits != 0) $display("FAIL ovw_busy_idle: got %0d busy cycles expected 0", busy_hits); else pass_cnt++;
        total_cnt++; if (bv_hits != 0) $display("FAIL ovw_early_result: got %0d pulses expected 0", bv_hits); else pass_cnt++;
        fire(1'b1, 1'b0);
        wait_beta(20, lat, seen);
        total_cnt++; if (!seen || lat != 6) $display("FAIL ovw_latency: got %0d expected 6", lat); else pass_cnt++;
        total_cnt++; if (bus.beta0 !== 32'sd0) $display("FAIL ovw_beta0: got %0d expected 0", bus.beta0); else pass_cnt++;
        total_cnt++; if (bus.beta1 !== 32'sd384) $display("FAIL ovw_beta1: got %0d expected 384", bus.beta1); else pass_cnt++;
    endtask

    task automatic test_saturation();
        int lat;
        bit seen;
        apply_inv(32'sh7FFF_FFFF, 20'sd0, 21'sd0);
        apply_xty(33'h1_FFFF_FFFF, 33'd0);
        fire(1'b1, 1'b1);
        wait_beta(20, lat, seen);
        total_cnt++; if (!seen || lat != 6) $display("FAIL satpos_latency: got %0d expected 6", lat); else pass_cnt++;
        total_cnt++; if (bus.beta0 !== 32'sh7FFF_FFFF) $display("FAIL satpos_beta0: got %h expected 7fffffff", bus.beta0); else pass_cnt++;
        total_cnt++; if (bus.beta1 !== 32'sd0) $display("FAIL satpos_beta1: got %0d expected 0", bus.beta1); else pass_cnt++;
        total_cnt++; if (bus.sat !== 1'b1) $display("FAIL satpos_sat: got %b expected 1", bus.sat); else pass_cnt++;
        repeat (5) idle();
        total_cnt++; if (bus.sat !== 1'b1) $display("FAIL sat_held: got %b expected 1", bus.sat); else pass_cnt++;
        apply_inv(32'sh8000_0000, 20'sd0, 21'sd0);
        fire(1'b1, 1'b1);
        wait_beta(20, lat, seen);
        total_cnt++; if (bus.beta0 !== 32'sh8000_0000) $display("FAIL satneg_beta0: got %h expected 80000000", bus.beta0); else pass_cnt++;
        total_cnt++; if (!seen || bus.sat !== 1'b1) $display("FAIL satneg_sat: got %b expected 1", bus.sat); else pass_cnt++;
        apply_inv(32'sd1024, 20'sd0, 21'sd64);
        apply_xty(33'd16, 33'd512);
        fire(1'b1, 1'b1);
        wait_beta(20, lat, seen);
        total_cnt++; if (!seen || bus.sat !== 1'b0) $display("FAIL sat_cleared: got %b expected 0", bus.sat); else pass_cnt++;
    endtask

    task automatic test_busy_drop();
        int busy_err, pulses, consec, pulse_at;
        bit prev_bv, exp_busy;
        logic signed [31:0] e0, e1, g0, g1;
        bit es;
        busy_err = 0; pulses = 0; consec = 0; pulse_at = -1; prev_bv = 1'b0;
        g0 = 'x; g1 = 'x;
        apply_inv(32'sd2000, 20'sd300, -21'sd150);
        apply_xty(33'd4000, 33'd7000);
        compute_expect(e0, e1, es);
        fire(1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            idle();
            exp_busy = (i >= 1 && i <= 5);
            if (bus.busy !== exp_busy) busy_err++;
            if (bus.beta_valid === 1'b1) begin
                pulses++;
                if (prev_bv) consec++;
                if (pulse_at < 0) begin
                    pulse_at = i;
                    g0 = bus.beta0;
                    g1 = bus.beta1;
                end
            end
            prev_bv = (bus.beta_valid === 1'b1);
            if (i == 3) begin
                bus.sy = 33'd99; bus.sxy = 33'd12345;
                bus.xty_valid = 1'b1;
            end
            if (i == 4) bus.xty_valid = 1'b0;
        end
        total_cnt++; if (busy_err != 0) $display("FAIL drop_busy_window: got %0d wrong cycles expected 0", busy_err); else pass_cnt++;
        total_cnt++; if (pulses != 1 || consec != 0) $display("FAIL drop_pulse_count: got %0d pulses expected 1", pulses); else pass_cnt++;
        total_cnt++; if (pulse_at != 6) $display("FAIL drop_latency: got %0d expected 6", pulse_at); else pass_cnt++;
        total_cnt++; if (g0 !== e0 || g1 !== e1) $display("FAIL drop_betas: got %0d,%0d expected %0d,%0d", g0, g1, e0, e1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bv_hits;
        bit seen, es;
        logic signed [31:0] e0, e1;
        apply_inv(32'sd1024, 20'sd0, 21'sd64);
        apply_xty(33'd16, 33'd512);
        fire(1'b1, 1'b1);
        wait_beta(20, lat, seen);
        total_cnt++; if (!seen || bus.beta0 !== 32'sd256) $display("FAIL rmid_pre_beta0: got %0d expected 256", bus.beta0); else pass_cnt++;
        apply_inv(32'sd3000, -20'sd77, 21'sd500);
        apply_xty(33'd800, 33'd900);
        fire(1'b1, 1'b1);
        repeat (3) idle();
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rmid_busy_m2: got %b expected 1", bus.busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.beta0 !== 32'sd0 || bus.beta1 !== 32'sd0) $display("FAIL rmid_betas: got %0d,%0d expected 0,0", bus.beta0, bus.beta1); else pass_cnt++;
        total_cnt++; if (bus.sat !== 1'b0 || bus.beta_valid !== 1'b0) $display("FAIL rmid_flags: got %b,%b expected 0,0", bus.sat, bus.beta_valid); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bv_hits = 0;
        for (int i = 0; i < 15; i++) begin
            idle();
            bv_hits += int'(bus.beta_valid);
        end
        total_cnt++; if (bv_hits != 0) $display("FAIL rmid_no_result: got %0d pulses expected 0", bv_hits); else pass_cnt++;
        apply_xty(33'd1234, 33'd4321);
        compute_expect(e0, e1, es);
        fire(1'b0, 1'b1);
        wait_beta(20, lat, seen);
        total_cnt++; if (!seen || lat != 6) $display("FAIL rmid_latency: got %0d expected 6", lat); else pass_cnt++;
        total_cnt++; if (bus.beta0 !== e0 || bus.beta1 !== e1) $display("FAIL rmid_post_betas: got %0d,%0d expected %0d,%0d", bus.beta0, bus.beta1, e0, e1); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, mode, gap;
        bit seen, es;
        logic signed [31:0] e0, e1;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                apply_inv($urandom, 20'($urandom), 21'($urandom));
                apply_xty({1'($urandom), 32'($urandom)}, {1'($urandom), 32'($urandom)});
            end else begin
                apply_inv(32'($urandom_range(0, 8191)) - 32'd4096,
                          20'($urandom_range(0, 2047)) - 20'd1024,
                          21'($urandom_range(0, 2047)) - 21'd1024);
                apply_xty(33'($urandom_range(0, 65535)), 33'($urandom_range(0, 65535)));
            end
            compute_expect(e0, e1, es);
            mode = int'($urandom_range(0, 2));
            gap  = int'($urandom_range(0, 5));
            case (mode)
                0: fire(1'b1, 1'b1);
                1: begin fire(1'b0, 1'b1); repeat (gap) idle(); fire(1'b1, 1'b0); end
                default: begin fire(1'b1, 1'b0); repeat (gap) idle(); fire(1'b0, 1'b1); end
            endcase
            wait_beta(20, lat, seen);
            total_cnt++; if (!seen || lat != 6) $display("FAIL rnd_latency[%0d]: got %0d expected 6", n, lat); else pass_cnt++;
            total_cnt++; if (bus.beta0 !== e0) $display("FAIL rnd_beta0[%0d]: got %0d expected %0d", n, bus.beta0, e0); else pass_cnt++;
            total_cnt++; if (bus.beta1 !== e1) $display("FAIL rnd_beta1[%0d]: got %0d expected %0d", n, bus.beta1, e1); else pass_cnt++;
            total_cnt++; if (bus.sat !== es) $display("FAIL rnd_sat[%0d]: got %b expected %b", n, bus.sat, es); else pass_cnt++;
            idle();
            total_cnt++; if (bus.beta_valid !== 1'b0) $display("FAIL rnd_pulse_width[%0d]: got %b expected 0", n, bus.beta_valid); else pass_cnt++;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.inv_valid = 1'b0;
        bus.xty_valid = 1'b0;
        bus.inv0 = '0; bus.inv1 = '0; bus.inv2 = '0;
        bus.sy   = '0; bus.sxy  = '0;
        test_reset();
        test_basic();
        test_overwrite();
        test_saturation();
        test_busy_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
